// File: rtl/cond_logic.sv
// Conditional-execution unit: decodes the instruction condition against the
// architectural NZCV flags, gates the write/branch requests, and owns the
// flags register. Gated outputs are combinational; Flags is the only state.
module cond_logic (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   input  logic       PCS,
   input  logic       RegW,
   input  logic       MemW,
   input  logic       NoWrite,
   output logic       PCSrc,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       CondEx,
   output logic [3:0] Flags
);

   localparam int unsigned FLAG_W = 4;

   logic n_flag;
   logic z_flag;
   logic c_flag;
   logic v_flag;
   logic ex;
   logic [FLAG_W-1:0] flags_q;

   assign n_flag = flags_q[3];
   assign z_flag = flags_q[2];
   assign c_flag = flags_q[1];
   assign v_flag = flags_q[0];

   // Condition decode, evaluated only against the registered flags
   always_comb begin
      CondEx = 1'b0;
      case (Cond)
         4'b0000: CondEx = z_flag;
         4'b0001: CondEx = ~z_flag;
         4'b0010: CondEx = c_flag;
         4'b0011: CondEx = ~c_flag;
         4'b0100: CondEx = n_flag;
         4'b0101: CondEx = ~n_flag;
         4'b0110: CondEx = v_flag;
         4'b0111: CondEx = ~v_flag;
         4'b1000: CondEx = c_flag & ~z_flag;
         4'b1001: CondEx = ~c_flag | z_flag;
         4'b1010: CondEx = ~(n_flag ^ v_flag);
         4'b1011: CondEx = n_flag ^ v_flag;
         4'b1100: CondEx = ~z_flag & ~(n_flag ^ v_flag);
         4'b1101: CondEx = z_flag | (n_flag ^ v_flag);
         4'b1110: CondEx = 1'b1;
         default: CondEx = 1'b0;
      endcase
   end

   // Request gating: an instruction only takes effect when valid and passing
   always_comb begin
      ex       = en & CondEx;
      PCSrc    = PCS & ex;
      RegWrite = RegW & ~NoWrite & ex;
      MemWrite = MemW & ex;
   end

   // Flags register; N,Z and C,V halves load independently
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q <= '0;
      end else begin
         if (ex && FlagW[1]) flags_q[3:2] <= ALUFlags[3:2];
         if (ex && FlagW[0]) flags_q[1:0] <= ALUFlags[1:0];
      end
   end

   assign Flags = flags_q;

endmodule
